// File: rtl/sonic_log_pkg.sv
// Shared types and constants for the SoNIC log-stream arbiter.
package sonic_log_pkg;

    localparam int LOG_DATA_W  = 512;
    localparam int LOG_DELAY_W = 16;
    localparam int DROP_CNT_W  = 32;

    localparam logic [DROP_CNT_W-1:0] DROP_SAT = '1;

    typedef struct packed {
        logic [LOG_DATA_W-1:0]  data;
        logic [LOG_DELAY_W-1:0] delay;
    } log_rec_t;

    function automatic logic [DROP_CNT_W-1:0] drop_inc(
        input logic [DROP_CNT_W-1:0] c
    );
        return (c == DROP_SAT) ? c : c + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sonic_log_fifo.sv
// Per-port record FIFO; head is combinational, no write-to-read bypass.
module sonic_log_fifo
    import sonic_log_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  logic     pop_i,
    input  log_rec_t wdata_i,
    output log_rec_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    log_rec_t      mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sonic_log_arbiter.sv
// Merges per-port log records into one registered valid/ready stream
// with round-robin arbitration and saturating per-port drop counters.
module sonic_log_arbiter
    import sonic_log_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = LOG_DATA_W,
    parameter int DELAY_W    = LOG_DELAY_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            ctrl_enable,
    input  logic                            ctrl_clear_drops,
    input  logic [NUM_PORTS*DATA_W-1:0]     log_data_in,
    input  logic [NUM_PORTS*DELAY_W-1:0]    log_delay_in,
    input  logic [NUM_PORTS-1:0]            log_valid_in,
    output logic [DATA_W-1:0]               wr_data,
    output logic [DELAY_W-1:0]              wr_delay,
    output logic [$clog2(NUM_PORTS)-1:0]    wr_port,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [NUM_PORTS*DROP_CNT_W-1:0] drop_count,
    output logic [NUM_PORTS-1:0]            fifo_nonempty
);

    localparam int PW = $clog2(NUM_PORTS);

    log_rec_t             rec_in [NUM_PORTS];
    log_rec_t             head   [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] drop;

    logic          load;
    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;

    logic [PW-1:0] ptr_q, ptr_d;
    log_rec_t      out_q, out_d;
    logic [PW-1:0] port_q, port_d;
    logic          valid_q, valid_d;

    logic [NUM_PORTS*DROP_CNT_W-1:0] drop_q, drop_d;

    assign load = !valid_q || wr_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign rec_in[p] = {log_data_in[p*DATA_W +: DATA_W],
                            log_delay_in[p*DELAY_W +: DELAY_W]};
        assign push[p]   = ctrl_enable && log_valid_in[p];
        assign pop[p]    = load && gnt_vld && (gnt_idx == PW'(p));
        assign drop[p]   = push[p] && full[p] && !pop[p];

        sonic_log_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_in),
            .rst_ni  (rst_n_in),
            .push_i  (push[p]),
            .pop_i   (pop[p]),
            .wdata_i (rec_in[p]),
            .head_o  (head[p]),
            .full_o  (full[p]),
            .empty_o (empty[p])
        );
    end

    // ptr_q holds the highest-priority port for the next grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_vld && !empty[ptr_q + PW'(i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ptr_q + PW'(i);
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        out_d   = out_q;
        port_d  = port_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        if (load) begin
            valid_d = gnt_vld;
            if (gnt_vld) begin
                out_d  = head[gnt_idx];
                port_d = gnt_idx;
                ptr_d  = gnt_idx + PW'(1);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ctrl_clear_drops) begin
                drop_d[p*DROP_CNT_W +: DROP_CNT_W] = '0;
            end else if (drop[p]) begin
                drop_d[p*DROP_CNT_W +: DROP_CNT_W] =
                    drop_inc(drop_q[p*DROP_CNT_W +: DROP_CNT_W]);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ptr_q   <= '0;
            out_q   <= '0;
            port_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            port_q  <= port_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign wr_data       = out_q.data;
    assign wr_delay      = out_q.delay;
    assign wr_port       = port_q;
    assign wr_valid      = valid_q;
    assign drop_count    = drop_q;
    assign fifo_nonempty = ~empty;

endmodule
